// File: rtl/proc_pkg.sv
// Shared processor definitions: loader FSM states, opcodes and instruction field positions.
// Instruction layout is {opcode[7:6], rd[5:4], rs1[3:2], rs2[1:0]}.
package proc_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 4;
    localparam int RS1_MSB = 3;
    localparam int RS1_LSB = 2;
    localparam int RS2_MSB = 1;
    localparam int RS2_LSB = 0;

    function automatic logic [1:0] get_opcode(input logic [7:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction
endpackage

// File: rtl/prog_mem.sv
// Program memory, DEPTH x IW: one synchronous write port, async read, synchronous clear.
// Writes are visible on the read port the cycle after; no backpressure.
module prog_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int IW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [IW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [IW-1:0] o_rdata
);
    logic [IW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Addresses beyond DEPTH (non power-of-two depths) read as empty words.
    assign o_rdata = (int'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;
endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader (header N, N instructions, optional checksum when PROG_LOADER_CHKSUM_EN is defined).
// One byte per cycle when in_valid && in_ready; in_ready is purely state-based, so stalls never drop bytes.
module prog_loader
    import proc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int IW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [IW-1:0] rd_instr,
    output logic [AW:0]   prog_len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          run_en
);
    localparam logic [AW:0] ONE = 1;

    state_t      r_state;
    state_t      w_next;
    logic [AW:0] r_len;
    logic [AW:0] r_ptr;
`ifdef PROG_LOADER_CHKSUM_EN
    logic [7:0]  r_sum;
`endif

    logic w_xfer;
    logic w_start_ok;
    logic w_hdr_bad;
    logic w_last;
    logic w_we;

    assign w_xfer     = in_valid && in_ready;
    assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign w_hdr_bad  = (in_data == 8'd0) || (int'(in_data) > DEPTH);
    assign w_last     = (r_ptr + ONE) == r_len;
    assign w_we       = (r_state == S_LOAD) && w_xfer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (start) w_next = S_HDR;
            S_HDR:  if (w_xfer) w_next = w_hdr_bad ? S_ERR : S_LOAD;
`ifdef PROG_LOADER_CHKSUM_EN
            S_LOAD: if (w_xfer && w_last) w_next = S_CHK;
            S_CHK:  if (w_xfer) w_next = (in_data == r_sum) ? S_DONE : S_ERR;
`else
            S_LOAD: if (w_xfer && w_last) w_next = S_DONE;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        run_en   = 1'b0;
        case (r_state)
            S_HDR, S_LOAD, S_CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: begin
                done   = 1'b1;
                run_en = 1'b1;
            end
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len <= '0;
            r_ptr <= '0;
`ifdef PROG_LOADER_CHKSUM_EN
            r_sum <= '0;
`endif
        end else if (w_start_ok) begin
            r_len <= '0;
            r_ptr <= '0;
`ifdef PROG_LOADER_CHKSUM_EN
            r_sum <= '0;
`endif
        end else if (r_state == S_HDR && w_xfer && !w_hdr_bad) begin
            r_len <= in_data[AW:0];
        end else if (w_we) begin
            r_ptr <= r_ptr + ONE;
`ifdef PROG_LOADER_CHKSUM_EN
            r_sum <= r_sum + in_data;
`endif
        end
    end

    assign prog_len = r_len;

    prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_mem (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_start_ok),
        .i_we    (w_we),
        .i_waddr (r_ptr[AW-1:0]),
        .i_wdata (IW'(in_data)),
        .i_raddr (rd_addr),
        .o_rdata (rd_instr)
    );
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of program-memory words.
REQ-002 SHALL have parameter AW, default 3: read-address width, $clog2(DEPTH).
REQ-003 SHALL have parameter IW, default 8: instruction width, format {opcode[7:6], rd[5:4], rs1[3:2], rs2[1:0]}.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a new load.
REQ-007 SHALL have port in_data  in  8  byte stream carrying header, instructions and checksum.
REQ-008 SHALL have port in_valid  in  1  in_data is valid.
REQ-009 SHALL have port in_ready  out  1  loader accepts a byte this cycle.
REQ-010 SHALL have port rd_addr  in  AW  fetch address from the processor core.
REQ-011 SHALL have port rd_instr  out  IW  instruction at rd_addr.
REQ-012 SHALL have port prog_len  out  AW+1  number of instructions loaded.
REQ-013 SHALL have port busy / done / err / run_en  out  1 each  status flags; run_en releases the core to fetch.

Function
REQ-014 SHALL implement FSM states IDLE, HDR, LOAD, CHK, DONE, ERR; a byte transfers only when in_valid && in_ready.
REQ-015 SHALL drive in_ready=1 only in HDR, LOAD and CHK; busy=1 in exactly those states.
REQ-016 SHALL, on start in IDLE, DONE or ERR: next cycle enter HDR, clear all memory words to 0, clear prog_len, sum and write pointer, and drop done, err and run_en.
REQ-017 SHALL ignore start in HDR, LOAD and CHK.
REQ-018 SHALL, in HDR, take the transferred byte as N; N==0 or N>DEPTH -> ERR; otherwise prog_len=N, go to LOAD.
REQ-019 SHALL, per LOAD transfer, write mem[ptr]=in_data, sum=(sum+in_data) mod 256, then ptr++; after the N-th byte go to CHK, or to DONE if the checksum is compiled out.
REQ-020 SHALL, in CHK, go to DONE if the byte equals sum, else ERR.
REQ-021 SHALL hold done=1 and run_en=1 in DONE, and err=1 with run_en=0 in ERR, until start or reset.
REQ-022 SHALL make rd_instr = mem[rd_addr] combinationally in every state; words not written read 0.
REQ-023 SHALL make a written word visible on rd_instr the cycle after its transfer.
REQ-024 SHALL hold in_ready constant across in_valid gaps (stalls); no byte is lost or duplicated.

Reset
REQ-025 SHALL, on reset asserted at any time including mid-load, asynchronously force IDLE, all memory words 0, prog_len 0, sum 0, ptr 0, and in_ready, busy, done, err, run_en all 0.

Configuration
REQ-026 SHALL, with PROG_LOADER_CHKSUM_EN defined, include state CHK and the trailing checksum byte per REQ-020.
REQ-027 SHALL, without PROG_LOADER_CHKSUM_EN, omit CHK and the sum register, go LOAD->DONE after the N-th byte, and never enter ERR from a checksum mismatch.

Structure
REQ-028 SHALL take the FSM state enum, the opcode constants ADD=00, SUB=01, AND=10, OR=11 and the instruction field positions from shared package proc_pkg.
REQ-029 SHALL place the memory array with its combinational read port in sub-module prog_mem (DEPTH x IW, one write port, one async read port, synchronous clear).

Verification
REQ-030 SHALL cover: checksum enabled, start; bytes 04,0D,7E,86,D3,E4 -> DONE, run_en=1, prog_len=4, rd_addr 0..3 returns 0D,7E,86,D3 and rd_addr 4 returns 00.
REQ-031 SHALL cover: the same stream with checksum E5 -> ERR, err=1, run_en=0.
REQ-032 SHALL cover: header 00 or 09 -> ERR after one transfer; no memory word written.
REQ-033 SHALL cover: in_valid toggled every other cycle during REQ-030 -> identical memory contents and final state.
REQ-034 SHALL cover: reset asserted after the 2nd instruction byte -> IDLE the same cycle, all outputs 0, all words read 00.
REQ-035 SHALL cover: start pulsed during LOAD -> ignored; start in DONE -> memory cleared, HDR, done=0.
